// File: rtl/rca_pipe_pkg.sv
// Shared definitions for rca_pipe: chunk sizing, parameter sanity check and the
// per-stage control record. RCA_PIPE_SUB_EN adds the subtract bit to the record.
package rca_pipe_pkg;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // True when the operand splits into equal, non-empty chunks.
  function automatic bit split_ok(input int unsigned width, input int unsigned stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
`ifdef RCA_PIPE_SUB_EN
    logic sub;
`endif
  } stage_ctrl_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple adder built from bit-level full adders; also exposes
// the carry into its MSB so the last stage can form signed overflow.
module rca_chunk
  import rca_pipe_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    cmsb  = cin;
    for (int i = 0; i < CW; i++) begin
      if (i == CW - 1) cmsb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: one CW-bit chunk per stage, carry registered between
// stages, valid/ready on both sides. Define RCA_PIPE_SUB_EN for the subtract port.
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = chunk_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("rca_pipe: STAGES must divide WIDTH into non-empty chunks, WIDTH >= 2");
  end

  // a_q doubles as skew and deskew storage: the low chunk is the next A chunk to
  // consume, finished sum chunks shift in from the top, so the sum lands aligned.
  stage_ctrl_t      ctrl_q [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [CW-1:0]    csum   [STAGES];
  logic [WIDTH-1:0] fold   [STAGES];
  logic [STAGES-1:0] cco;
  logic [STAGES-1:0] cmsb;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             advance;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] b_eff;
`ifdef RCA_PIPE_SUB_EN
    assign b_eff = b_q[k][CW-1:0] ^ {CW{ctrl_q[k].sub}};
`else
    assign b_eff = b_q[k][CW-1:0];
`endif
    rca_chunk #(
      .CW(CW)
    ) u_chunk (
      .a   (a_q[k][CW-1:0]),
      .b   (b_eff),
      .cin (ctrl_q[k].carry),
      .sum (csum[k]),
      .cout(cco[k]),
      .cmsb(cmsb[k])
    );
    assign fold[k] = (a_q[k] >> CW) | (WIDTH'(csum[k]) << (WIDTH - CW));
  end

  // Stage data only loads under a valid beat, so outputs keep the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      ctrl_q[0].valid <= in_valid;
      if (in_valid) begin
        a_q[0] <= a;
        b_q[0] <= b;
`ifdef RCA_PIPE_SUB_EN
        ctrl_q[0].sub   <= sub;
        ctrl_q[0].carry <= sub | cin;
`else
        ctrl_q[0].carry <= cin;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        ctrl_q[k].valid <= ctrl_q[k-1].valid;
        if (ctrl_q[k-1].valid) begin
          a_q[k]          <= fold[k-1];
          b_q[k]          <= b_q[k-1] >> CW;
          ctrl_q[k].carry <= cco[k-1];
`ifdef RCA_PIPE_SUB_EN
          ctrl_q[k].sub   <= ctrl_q[k-1].sub;
`endif
        end
      end
      out_valid_q <= ctrl_q[STAGES-1].valid;
      if (ctrl_q[STAGES-1].valid) begin
        sum_q  <= fold[STAGES-1];
        cout_q <= cco[STAGES-1];
        ovf_q  <= cco[STAGES-1] ^ cmsb[STAGES-1];
      end
    end
  end

  // Upper B bits of the last stage and inner-chunk MSB carries have no consumer.
  logic unused_bits;
  assign unused_bits = ^{b_q[STAGES-1], cmsb};

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe: vector table plus stall and mid-flight reset sequences.
module tb_rca_pipe;
  parameter int unsigned STAGES = 4;
  localparam int unsigned WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          rdy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef RCA_PIPE_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   checks = 0;
  int   errors = 0;
  int   nret = 0;
  int   cyc = 0;
  int   lat;
  exp_t expq[$];
  vec_t vecs[$];
  exp_t mon_e;

  rca_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef RCA_PIPE_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                              input logic vsub, input logic [15:0] vs, input logic vc,
                              input logic vo);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub; v.s = vs; v.c = vc; v.o = vo;
    return v;
  endfunction

  // Holds the beat until accepted; records the expected result and earliest arrival.
  task automatic send(input vec_t v);
    bit   done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    cin = v.cin;
`ifdef RCA_PIPE_SUB_EN
    sub = v.sub;
`endif
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = v.s; e.c = v.c; e.o = v.o; e.rdy = cyc + 1 + STAGES;
        expq.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        mon_e = expq.pop_front();
        check("sum", sum, mon_e.s);
        check("cout", cout, mon_e.c);
        check("ovf", ovf, mon_e.o);
        check("not_early", (cyc >= mon_e.rdy), 1'b1);
        nret++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
    vecs.push_back(mk(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mk(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1));
`ifdef RCA_PIPE_SUB_EN
    vecs.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
    vecs.push_back(mk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0));
`endif

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("idle_out_valid", out_valid, 1'b0);

    // Single beat latency
    send(vecs[0]);
    check("first_not_early", out_valid, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, STAGES);
    drain();

    // Whole table back-to-back
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Eight back-to-back beats with out_ready low in cycles 6..8
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(mk(16'(i), 16'(16'h1000 * i), 1'b0, 1'b0, 16'(16'h1001 * i), 1'b0, 1'b0));
      end
      begin
        for (int c = 0; c < 12; c++) begin
          bit exp_ov;
          out_ready = !(c >= 6 && c <= 8);
          @(negedge clk);
          if (c >= 6 && c <= 8) begin
            exp_ov = (expq.size() > 0) && (cyc >= expq[0].rdy);
            check("stall_out_valid", out_valid, exp_ov);
            check("stall_in_ready", in_ready, !exp_ov);
            if (exp_ov) begin
              check("stall_hold_sum", sum, expq[0].s);
              check("stall_hold_cout", cout, expq[0].c);
            end
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("retired_count", nret, 1 + vecs.size() + 8);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(mk(16'(16'hA000 + i), 16'h0101, 1'b0, 1'b0, 16'(16'hA101 + i), 1'b0, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    expq.delete();
    repeat (STAGES + 4) begin
      @(negedge clk);
      check("flush_no_beat", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Pipe works again after the flush
    send(vecs[2]);
    send(vecs[1]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
